// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60 raster constants, total-count helpers and sync polarity type.
// Shared by the timing generator, its interface and the bench.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COORD_W  = 10;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run/freeze control in, strobe, syncs and coordinates out.
// master = timing generator side, slave = renderer side that owns enable.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) ();

    logic               enable;
    logic               pix_stb;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  enable,
        output pix_stb, hsync, vsync, active, x, y, line_start, frame_start
    );

    modport slave (
        output enable,
        input  pix_stb, hsync, vsync, active, x, y, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_strobe.sv
// Fractional clock-enable: CLK_INC strobes per CLK_MOD enabled cycles, registered.
// Strobe is gated by enable; the accumulator and pending strobe freeze while enable is low.
module vga_pixel_strobe #(
    parameter int CLK_INC = 1,
    parameter int CLK_MOD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic pix_stb
);

    localparam int               ACC_W = $clog2(CLK_MOD) + 1;
    localparam logic [ACC_W-1:0] INC_C = ACC_W'(CLK_INC);
    localparam logic [ACC_W-1:0] MOD_C = ACC_W'(CLK_MOD);

    generate
        if (CLK_INC < 1 || CLK_INC > CLK_MOD) begin : g_bad_inc
            $error("vga_pixel_strobe: CLK_INC must satisfy 1 <= CLK_INC <= CLK_MOD");
        end
    endgenerate

    logic [ACC_W-1:0] r_acc;
    logic             r_stb;
    logic [ACC_W-1:0] w_sum;

    // acc < MOD and INC <= MOD, so the sum never exceeds 2*MOD-1 and fits ACC_W bits
    assign w_sum = r_acc + INC_C;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_stb <= 1'b0;
        end else if (enable) begin
            if (w_sum >= MOD_C) begin
                r_acc <= w_sum - MOD_C;
                r_stb <= 1'b1;
            end else begin
                r_acc <= w_sum;
                r_stb <= 1'b0;
            end
        end
    end

    assign pix_stb = r_stb & enable;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters stepped by a fractional pixel strobe, registered decodes.
// Each pixel is held from the strobe that enters it to the strobe that leaves it; enable low freezes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_INC  = 1,
    parameter int CLK_MOD  = 4,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int COORD_W  = DEF_COORD_W
) (
    input logic             clock,
    input logic             reset,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    localparam sync_pol_e          POL     = (SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
    localparam logic               SYNC_ON = POL;
    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

    generate
        if ((H_TOTAL - 1) >= (2 ** COORD_W) || (V_TOTAL - 1) >= (2 ** COORD_W)) begin : g_bad_coord
            $error("vga_timing_gen: COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    logic               w_pix_stb;
    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic [COORD_W-1:0] w_h_nxt;
    logic [COORD_W-1:0] w_v_nxt;
    logic               r_active;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_h_zero;
    logic               r_v_zero;

    vga_pixel_strobe #(
        .CLK_INC (CLK_INC),
        .CLK_MOD (CLK_MOD)
    ) u_pix_stb (
        .clock   (clock),
        .reset   (reset),
        .enable  (vif.enable),
        .pix_stb (w_pix_stb)
    );

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (w_pix_stb) begin
            if (r_h == H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + ONE;
            end else begin
                w_h_nxt = r_h + ONE;
            end
        end
    end

    // Decodes are computed from the next count so they land together with it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h      <= '0;
            r_v      <= '0;
            r_active <= 1'b1;
            r_hsync  <= ~SYNC_ON;
            r_vsync  <= ~SYNC_ON;
            r_h_zero <= 1'b1;
            r_v_zero <= 1'b1;
        end else if (w_pix_stb) begin
            r_h      <= w_h_nxt;
            r_v      <= w_v_nxt;
            r_active <= (int'(w_h_nxt) < H_ACTIVE) && (int'(w_v_nxt) < V_ACTIVE);
            r_hsync  <= ((int'(w_h_nxt) >= HS_BEG) && (int'(w_h_nxt) < HS_END)) ? SYNC_ON : ~SYNC_ON;
            r_vsync  <= ((int'(w_v_nxt) >= VS_BEG) && (int'(w_v_nxt) < VS_END)) ? SYNC_ON : ~SYNC_ON;
            r_h_zero <= (w_h_nxt == '0);
            r_v_zero <= (w_v_nxt == '0);
        end
    end

    assign vif.pix_stb     = w_pix_stb;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.active      = r_active;
    assign vif.x           = r_h;
    assign vif.y           = r_v;
    assign vif.line_start  = w_pix_stb & r_h_zero;
    assign vif.frame_start = w_pix_stb & r_h_zero & r_v_zero;

endmodule
